// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: converts a Cartesian (x, y) pair into an
// unsigned magnitude and a 32-bit binary angle (atan2), one vector at a time.
module cordic_vector #(
    parameter int DATA_W = 16,
    parameter int ITER   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] y_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W:0]          mag_out,
    output logic [31:0]              angle_out
);

    // Two guard bits absorb negation of the most-negative input plus the CORDIC gain.
    localparam int          W     = DATA_W + 2;
    localparam logic [15:0] INV_K = 16'h9B75;

    typedef enum logic [1:0] {IDLE, ROTATE, SCALE, DONE} state_t;

    state_t              r_state;
    logic signed [W-1:0] r_x;
    logic signed [W-1:0] r_y;
    logic [31:0]         r_z;
    logic [4:0]          r_iter;
    logic                r_zero;

    logic signed [W-1:0] w_xExt;
    logic signed [W-1:0] w_yExt;
    logic signed [W-1:0] w_xShift;
    logic signed [W-1:0] w_yShift;
    logic [31:0]         w_atan;
    logic [W+14:0]       w_prod;

    function automatic logic [31:0] atanLut(input logic [4:0] idx);
        case (idx)
            5'd0:    atanLut = 32'h20000000;
            5'd1:    atanLut = 32'h12E4051E;
            5'd2:    atanLut = 32'h09FB385B;
            5'd3:    atanLut = 32'h051111D4;
            5'd4:    atanLut = 32'h028B0D43;
            5'd5:    atanLut = 32'h0145D7E1;
            5'd6:    atanLut = 32'h00A2F61E;
            5'd7:    atanLut = 32'h00517C55;
            5'd8:    atanLut = 32'h0028BE53;
            5'd9:    atanLut = 32'h00145F2F;
            5'd10:   atanLut = 32'h000A2F98;
            5'd11:   atanLut = 32'h000517CC;
            5'd12:   atanLut = 32'h00028BE6;
            5'd13:   atanLut = 32'h000145F3;
            5'd14:   atanLut = 32'h0000A2FA;
            5'd15:   atanLut = 32'h0000517D;
            default: atanLut = 32'h00000000;
        endcase
    endfunction

    assign w_xExt   = {{2{x_in[DATA_W-1]}}, x_in};
    assign w_yExt   = {{2{y_in[DATA_W-1]}}, y_in};
    assign w_xShift = r_x >>> r_iter;
    assign w_yShift = r_y >>> r_iter;
    assign w_atan   = atanLut(r_iter);
    // The final x is never negative, so its sign bit is dropped before scaling by 1/K.
    assign w_prod   = {{16{1'b0}}, r_x[W-2:0]} * {{(W-1){1'b0}}, INV_K};

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_iter    <= '0;
            r_zero    <= 1'b0;
            mag_out   <= '0;
            angle_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // Left half-plane vectors are pre-rotated by 180 degrees.
                        if (x_in[DATA_W-1]) begin
                            r_x <= -w_xExt;
                            r_y <= -w_yExt;
                            r_z <= 32'h80000000;
                        end else begin
                            r_x <= w_xExt;
                            r_y <= w_yExt;
                            r_z <= 32'h00000000;
                        end
                        r_zero  <= (x_in == '0) && (y_in == '0);
                        r_iter  <= '0;
                        r_state <= ROTATE;
                    end
                end
                ROTATE: begin
                    if (!r_y[W-1]) begin
                        r_x <= r_x + w_yShift;
                        r_y <= r_y - w_xShift;
                        r_z <= r_z + w_atan;
                    end else begin
                        r_x <= r_x - w_yShift;
                        r_y <= r_y + w_xShift;
                        r_z <= r_z - w_atan;
                    end
                    if (r_iter == 5'(ITER - 1)) begin
                        r_state <= SCALE;
                    end else begin
                        r_iter <= r_iter + 5'd1;
                    end
                end
                SCALE: begin
                    // A zero vector has no defined angle; force a clean all-zero result.
                    if (r_zero) begin
                        mag_out   <= '0;
                        angle_out <= '0;
                    end else begin
                        mag_out   <= w_prod[W+14:16];
                        angle_out <= r_z;
                    end
                    r_state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vector.sv
// Directed, table-driven bench for cordic_vector: quadrant sweep, extremes,
// latency, backpressure and mid-rotation reset, against hand-computed results.
module tb_cordic_vector;

    localparam int DATA_W = 16;
    localparam int ITER   = 16;

    logic                     clk;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] y_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W:0]          mag_out;
    logic [31:0]              angle_out;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        string       name;
        int          xv;
        int          yv;
        int          expMag;
        int          magTol;
        logic [31:0] expAngle;
        int          angTol;
    } vec_t;

    cordic_vector #(.DATA_W(DATA_W), .ITER(ITER)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .angle_out (angle_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] simulation timed out");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkEq(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Tolerances cover the truncating shifts inside the iterations.
    task automatic checkOutput(input string name, input int expMag, input int magTol,
                               input logic [31:0] expAngle, input int angTol);
        int          magDiff;
        logic [31:0] rawDiff;
        int          angDiff;
        magDiff = int'(mag_out) - expMag;
        if (magDiff < 0) magDiff = -magDiff;
        nCompared++;
        if (magDiff > magTol) begin
            nMismatched++;
            $display("[TB] FAIL %s mag: got %0d, want %0d +/- %0d", name, mag_out, expMag, magTol);
        end
        rawDiff = angle_out - expAngle;
        angDiff = $signed(rawDiff);
        if (angDiff < 0) angDiff = -angDiff;
        nCompared++;
        if (angDiff > angTol) begin
            nMismatched++;
            $display("[TB] FAIL %s angle: got 0x%08h, want 0x%08h +/- 0x%0h", name, angle_out, expAngle, angTol);
        end
    endtask

    // Presents a vector and returns once the accepting edge has passed.
    task automatic applyStimulus(input string name, input int xv, input int yv);
        int waited;
        x_in     = 16'(xv);
        y_in     = 16'(yv);
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL %s accept: got in_ready=0 after %0d cycles, want 1", name, waited);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitResult(input string name, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 200) begin
            tick();
            cycles++;
        end
        if (!out_valid) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL %s result: got no out_valid in %0d cycles, want one", name, cycles);
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   cycles;
        int   seen;

        vecs[0] = '{"pos_x",     16384,      0, 16384, 4, 32'h00000000, 32'h20000};
        vecs[1] = '{"pos_y",         0,  16384, 16384, 4, 32'h40000000, 32'h20000};
        vecs[2] = '{"neg_x",    -16384,      0, 16384, 4, 32'h80000000, 32'h20000};
        vecs[3] = '{"q3_diag",  -16384, -16384, 23170, 4, 32'hA0000000, 32'h20000};
        vecs[4] = '{"q4_diag",   16384, -16384, 23170, 4, 32'hE0000000, 32'h20000};
        vecs[5] = '{"min_diag", -32768, -32768, 46341, 4, 32'hA0000000, 32'h20000};
        vecs[6] = '{"zero",          0,      0,     0, 0, 32'h00000000, 0};

        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;
        reset     = 1'b1;
        #1 reset  = 1'b0;
        #2;
        checkEq("reset in_ready", int'(in_ready), 1);
        checkEq("reset out_valid", int'(out_valid), 0);
        checkEq("reset mag_out", int'(mag_out), 0);
        checkEq("reset angle_out", int'(angle_out), 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Quadrant sweep and extremes with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].name, vecs[i].xv, vecs[i].yv);
            waitResult(vecs[i].name, cycles);
            checkEq({vecs[i].name, " latency"}, cycles, ITER + 1);
            checkOutput(vecs[i].name, vecs[i].expMag, vecs[i].magTol,
                        vecs[i].expAngle, vecs[i].angTol);
            tick();
            checkEq({vecs[i].name, " consumed"}, int'(out_valid), 0);
            checkEq({vecs[i].name, " ready again"}, int'(in_ready), 1);
        end

        // Backpressure: result must hold and a second vector must wait.
        out_ready = 1'b0;
        applyStimulus("bp_first", 16384, 16384);
        waitResult("bp_first", cycles);
        x_in     = -16'sd20000;
        y_in     = 16'sd0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkEq("bp hold out_valid", int'(out_valid), 1);
            checkEq("bp hold in_ready", int'(in_ready), 0);
            checkOutput("bp hold", 23170, 4, 32'h20000000, 32'h20000);
        end
        out_ready = 1'b1;
        tick();
        checkEq("bp handshake out_valid", int'(out_valid), 0);
        checkEq("bp handshake in_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        checkEq("bp second accepted", int'(in_ready), 0);
        waitResult("bp_second", cycles);
        checkEq("bp_second latency", cycles, ITER + 1);
        checkOutput("bp_second", 20000, 4, 32'h80000000, 32'h20000);
        tick();

        // Reset during the sixth micro-rotation aborts the vector.
        applyStimulus("abort", 16384, 0);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        #1;
        checkEq("abort in_ready", int'(in_ready), 1);
        checkEq("abort out_valid", int'(out_valid), 0);
        tick();
        reset = 1'b1;
        seen  = 0;
        for (int i = 0; i < ITER + 5; i++) begin
            tick();
            if (out_valid) seen = 1;
        end
        checkEq("abort no result", seen, 0);
        checkEq("abort idle ready", int'(in_ready), 1);

        applyStimulus("post_abort", 3000, 4000);
        waitResult("post_abort", cycles);
        checkEq("post_abort latency", cycles, ITER + 1);
        checkOutput("post_abort", 5000, 4, 32'h25C80A3C, 32'h40000);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
